clock_group_reset_sequencer: RTL and testbench

CLOCK_GROUP_RESET_SEQUENCER -- requirements
Module: clock_group_reset_sequencer

---
 rtl/clock_group_reset_sequencer.sv | 125 ++++++++++++
 tb/tb_clock_group_reset_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/clock_group_reset_sequencer.sv
// Staggered reset release for a group of clock-broadcast sinks: all outputs hold
// for HOLD_CYCLES after the reset source goes quiet, then release one by one.
module clock_group_reset_sequencer #(
  parameter int NUM_OUT        = 5,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic               auto_in_clock,
  input  logic               auto_in_reset,
  input  logic               sw_reset_req,
  output logic               auto_out_clock,
  output logic [NUM_OUT-1:0] auto_out_reset,
  output logic               done,
  output logic [1:0]         state_o
);

  localparam int MAX_CYC = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int IDX_W   = $clog2(NUM_OUT) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [NUM_OUT-1:0] rst_reg, rst_next;
  logic               done_reg, done_next;

  // The clock is forwarded untouched so every sink sees the source edge.
  assign auto_out_clock = auto_in_clock;
  assign auto_out_reset = rst_reg;
  assign done           = done_reg;
  assign state_o        = state_reg;

  always_ff @(posedge auto_in_clock) begin
    if (auto_in_reset) begin
      state_reg <= ST_ASSERT;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      rst_reg   <= '1;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      rst_reg   <= rst_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    rst_next   = rst_reg;
    done_next  = done_reg;

    if (sw_reset_req) begin
      // A held request pins cnt at zero, so the hold starts after it drops.
      state_next = ST_ASSERT;
      cnt_next   = '0;
      idx_next   = '0;
      rst_next   = '1;
      done_next  = 1'b0;
    end else begin
      case (state_reg)
        ST_ASSERT: begin
          rst_next  = '1;
          done_next = 1'b0;
          if (cnt_reg == HOLD_LAST) begin
            rst_next[0] = 1'b0;
            cnt_next    = '0;
            idx_next    = IDX_W'(1);
            if (NUM_OUT == 1) begin
              state_next = ST_RUN;
              done_next  = 1'b1;
            end else begin
              state_next = ST_RELEASE;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (cnt_reg == STAG_LAST) begin
            for (int i = 0; i < NUM_OUT; i++) begin
              if (idx_reg == IDX_W'(i)) rst_next[i] = 1'b0;
            end
            idx_next = idx_reg + IDX_W'(1);
            cnt_next = '0;
            if (idx_reg == IDX_LAST) begin
              state_next = ST_RUN;
              done_next  = 1'b1;
            end
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end

        ST_RUN: begin
          rst_next  = '0;
          done_next = 1'b1;
        end

        default: begin
          state_next = ST_ASSERT;
          cnt_next   = '0;
          idx_next   = '0;
          rst_next   = '1;
          done_next  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Scoreboard bench for the reset sequencer: three configurations share one stimulus
// stream, expectations come from an "edges since last re-reset" timeline model.
module tb_clock_group_reset_sequencer;

  localparam int NCYC = 800;

  logic clk = 1'b0;
  logic rst_in;
  logic sw_req;

  logic       clk0, clk1, clk2;
  logic [4:0] r0;
  logic [0:0] r1;
  logic [4:0] r2;
  logic       d0, d1, d2;
  logic [1:0] s0, s1, s2;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int         cyc;
    logic       rst;
    logic       sw;
    int         t;
    logic [7:0] er0, er1, er2;
    logic       ed0, ed1, ed2;
    logic [1:0] es0, es1, es2;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  clock_group_reset_sequencer u0 (
    .auto_in_clock(clk), .auto_in_reset(rst_in), .sw_reset_req(sw_req),
    .auto_out_clock(clk0), .auto_out_reset(r0), .done(d0), .state_o(s0));

  clock_group_reset_sequencer #(.NUM_OUT(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1)) u1 (
    .auto_in_clock(clk), .auto_in_reset(rst_in), .sw_reset_req(sw_req),
    .auto_out_clock(clk1), .auto_out_reset(r1), .done(d1), .state_o(s1));

  clock_group_reset_sequencer #(.NUM_OUT(5), .HOLD_CYCLES(3), .STAGGER_CYCLES(1)) u2 (
    .auto_in_clock(clk), .auto_in_reset(rst_in), .sw_reset_req(sw_req),
    .auto_out_clock(clk2), .auto_out_reset(r2), .done(d2), .state_o(s2));

  // t = edges since the last edge that sampled a reset source (that edge is t=0).
  function automatic logic [7:0] m_rst(int t, int n, int h, int s);
    logic [7:0] r = '0;
    for (int i = 0; i < n; i++) r[i] = (t < h + i * s);
    return r;
  endfunction

  function automatic logic m_done(int t, int n, int h, int s);
    return t >= h + (n - 1) * s;
  endfunction

  function automatic logic [1:0] m_state(int t, int n, int h, int s);
    if (t >= h + (n - 1) * s) return 2'd2;
    if (t >= h) return 2'd1;
    return 2'd0;
  endfunction

  int t_model = 0;

  task automatic push_edge(int cyc);
    exp_t e;
    if (rst_in || sw_req) t_model = 0;
    else if (t_model < 100000) t_model++;
    e.cyc = cyc; e.rst = rst_in; e.sw = sw_req; e.t = t_model;
    e.er0 = m_rst(t_model, 5, 16, 4); e.ed0 = m_done(t_model, 5, 16, 4); e.es0 = m_state(t_model, 5, 16, 4);
    e.er1 = m_rst(t_model, 1, 1, 1);  e.ed1 = m_done(t_model, 1, 1, 1);  e.es1 = m_state(t_model, 1, 1, 1);
    e.er2 = m_rst(t_model, 5, 3, 1);  e.ed2 = m_done(t_model, 5, 3, 1);  e.es2 = m_state(t_model, 5, 3, 1);
    q.push_back(e);
  endtask

  task automatic chk(string name, int cyc, logic [7:0] act, logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Stimulus: directed opening (power-on reset, full sequence, sw pulses, combined
  // reset) followed by sparse random reset/sw events with occasional held requests.
  initial begin
    int hold_cnt = 0;
    int r;
    rst_in = 1'b1;
    sw_req = 1'b0;
    push_edge(0);
    for (int c = 1; c <= NCYC; c++) begin
      @(negedge clk);
      rst_in = 1'b0;
      sw_req = 1'b0;
      if (c <= 2) rst_in = 1'b1;
      else if (c == 43 || c == 65) sw_req = 1'b1;
      else if (c == 81) begin rst_in = 1'b1; sw_req = 1'b1; end
      else if (c > 120) begin
        r = int'($urandom_range(0, 99));
        if (hold_cnt > 0) begin
          sw_req = 1'b1;
          hold_cnt--;
        end else if (r < 2) rst_in = 1'b1;
        else if (r < 4) sw_req = 1'b1;
        else if (r == 4) begin
          sw_req = 1'b1;
          hold_cnt = int'($urandom_range(1, 4));
        end
        if ($urandom_range(0, 9) == 0 && r < 3) sw_req = 1'b1;
      end
      push_edge(c);
    end
  end

  // Monitor: one transaction per rising edge, sampled just after it.
  initial begin
    exp_t e;
    for (int n = 0; n <= NCYC; n++) begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL scoreboard_empty at sample %0d: got 0 entries want 1", n);
      end else begin
        e = q.pop_front();
        $display("[TB] cyc %0d rst=%b sw=%b t=%0d | u0 %b d%b s%0d | u1 %b d%b s%0d | u2 %b d%b s%0d",
                 e.cyc, e.rst, e.sw, e.t, r0, d0, s0, r1, d1, s1, r2, d2, s2);
        chk("u0_reset", e.cyc, {3'b0, r0}, e.er0);
        chk("u0_done",  e.cyc, {7'b0, d0}, {7'b0, e.ed0});
        chk("u0_state", e.cyc, {6'b0, s0}, {6'b0, e.es0});
        chk("u1_reset", e.cyc, {7'b0, r1}, e.er1);
        chk("u1_done",  e.cyc, {7'b0, d1}, {7'b0, e.ed1});
        chk("u1_state", e.cyc, {6'b0, s1}, {6'b0, e.es1});
        chk("u2_reset", e.cyc, {3'b0, r2}, e.er2);
        chk("u2_done",  e.cyc, {7'b0, d2}, {7'b0, e.ed2});
        chk("u2_state", e.cyc, {6'b0, s2}, {6'b0, e.es2});
        chk("clock_passthru", e.cyc, {5'b0, clk0, clk1, clk2}, {5'b0, clk, clk, clk});
      end
      @(negedge clk);
      #1;
      chk("clock_passthru_low", n, {5'b0, clk0, clk1, clk2}, {5'b0, clk, clk, clk});
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #((NCYC + 50) * 10);
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
